// File: rtl/ram_port_controller.sv
// ram_port_controller
// Sequencing initiator for a 16 x 4 register-file RAM. Takes one read or write
// request at a time over a valid/ready handshake. It drives the RAM address,
// data and write strobe through setup, strobe and hold phases so that the
// address is stable around the strobe. After a write it optionally reads the
// word back and flags any difference from the data that was written.
//
// Parameters
//   HoldCycles  number of cycles (1..7) that address/data stay stable after the
//               write strobe falls
//   Verify      1: compare the read-back value against the written data
//
// Ports
//   clk_i, rst_i                  clock; asynchronous active-high reset
//   req_valid_i / req_ready_o     request handshake
//   req_write_i                   1 = write, 0 = read
//   req_addr_i, req_data_i        word address and write data
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_data_o, rsp_mismatch_o    read data or read-back value, and the
//                                 write-verify flag
//   ram_addr_o, ram_data_o        RAM address/select and data-in buses
//   ram_write_o                   RAM write strobe (registered)
//   ram_read_data_i               RAM selected-word output
`timescale 1ns/1ps
module ram_port_controller #(
  parameter int unsigned HoldCycles = 1,
  parameter bit          Verify     = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  logic [3:0] req_addr_i,
  input  logic [3:0] req_data_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [3:0] rsp_data_o,
  output logic       rsp_mismatch_o,
  output logic [3:0] ram_addr_o,
  output logic [3:0] ram_data_o,
  output logic       ram_write_o,
  input  logic [3:0] ram_read_data_i
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StSample,
    StResp
  } state_e;

  localparam logic [2:0] HoldLoad = 3'(HoldCycles);

  state_e     state_q, state_d;
  logic       wr_q, wr_d;
  logic [3:0] ram_addr_q, ram_addr_d;
  // This register also holds the captured write data that the read-back is compared against.
  logic [3:0] ram_data_q, ram_data_d;
  logic       ram_write_q, ram_write_d;
  logic [2:0] hold_cnt_q, hold_cnt_d;
  logic       req_ready_q, req_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [3:0] rsp_data_q, rsp_data_d;
  logic       rsp_mis_q, rsp_mis_d;

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    ram_write_d = ram_write_q;
    hold_cnt_d  = hold_cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_mis_d   = rsp_mis_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          // The request is captured straight onto the RAM buses, so the SETUP cycle already drives them.
          wr_d        = req_write_i;
          ram_addr_d  = req_addr_i;
          ram_data_d  = req_data_i;
          req_ready_d = 1'b0;
          state_d     = StSetup;
        end
      end
      StSetup: begin
        if (wr_q) begin
          ram_write_d = 1'b1;
          state_d     = StStrobe;
        end else begin
          state_d = StSample;
        end
      end
      StStrobe: begin
        ram_write_d = 1'b0;
        hold_cnt_d  = HoldLoad;
        state_d     = StHold;
      end
      StHold: begin
        if (hold_cnt_q <= 3'd1) begin
          rsp_data_d  = ram_read_data_i;
          rsp_mis_d   = Verify && (ram_read_data_i != ram_data_q);
          rsp_valid_d = 1'b1;
          hold_cnt_d  = 3'd0;
          state_d     = StResp;
        end else begin
          hold_cnt_d = hold_cnt_q - 3'd1;
        end
      end
      StSample: begin
        rsp_data_d  = ram_read_data_i;
        rsp_mis_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        ram_write_d = 1'b0;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      wr_q        <= 1'b0;
      ram_addr_q  <= 4'h0;
      ram_data_q  <= 4'h0;
      ram_write_q <= 1'b0;
      hold_cnt_q  <= 3'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 4'h0;
      rsp_mis_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_write_q <= ram_write_d;
      hold_cnt_q  <= hold_cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_mis_q   <= rsp_mis_d;
    end
  end

  assign req_ready_o    = req_ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_mismatch_o = rsp_mis_q;
  assign ram_addr_o     = ram_addr_q;
  assign ram_data_o     = ram_data_q;
  assign ram_write_o    = ram_write_q;

endmodule

// File: tb/tb_ram_port_controller.sv
// Bench for ram_port_controller: two instances (HoldCycles=1/Verify=1 and
// HoldCycles=3/Verify=0), each with its own RAM model. Expected responses are
// queued at accept time and popped by a negedge monitor on each handshake.
`timescale 1ns/1ps
module tb_ram_port_controller;

  localparam int H0 = 1;
  localparam int H1 = 3;
  localparam bit V0 = 1'b1;
  localparam bit V1 = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_mis, ram_write;
  logic [1:0][3:0] req_addr, req_data, rsp_data, ram_addr, ram_data, ram_rd;

  ram_port_controller #(.HoldCycles(H0), .Verify(V0)) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_write_i(req_write[0]),
    .req_addr_i(req_addr[0]), .req_data_i(req_data[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_data_o(rsp_data[0]),
    .rsp_mismatch_o(rsp_mis[0]), .ram_addr_o(ram_addr[0]), .ram_data_o(ram_data[0]),
    .ram_write_o(ram_write[0]), .ram_read_data_i(ram_rd[0])
  );

  ram_port_controller #(.HoldCycles(H1), .Verify(V1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_write_i(req_write[1]),
    .req_addr_i(req_addr[1]), .req_data_i(req_data[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_data_o(rsp_data[1]),
    .rsp_mismatch_o(rsp_mis[1]), .ram_addr_o(ram_addr[1]), .ram_data_o(ram_data[1]),
    .ram_write_o(ram_write[1]), .ram_read_data_i(ram_rd[1])
  );

  // RAM models; bad[k] makes word 15 read back as 0x3 regardless of contents.
  logic [3:0] mem0 [16] = '{default: 4'h0};
  logic [3:0] mem1 [16] = '{default: 4'h0};
  logic [1:0] bad = 2'b00;

  always @(posedge clk) begin
    if (ram_write[0]) mem0[ram_addr[0]] <= ram_data[0];
    if (ram_write[1]) mem1[ram_addr[1]] <= ram_data[1];
  end

  assign ram_rd[0] = (bad[0] && ram_addr[0] == 4'hF) ? 4'h3 : mem0[ram_addr[0]];
  assign ram_rd[1] = (bad[1] && ram_addr[1] == 4'hF) ? 4'h3 : mem1[ram_addr[1]];

  typedef struct {
    logic [3:0] d;
    logic       m;
    bit         w;
    time        t;
  } exp_t;

  exp_t       sb0[$];
  exp_t       sb1[$];
  logic [3:0] ref_mem [2][16];
  bit         busy[2], rel[2], have[2], cur_w[2];
  logic [3:0] cur_a[2], cur_d[2];
  time        cur_t[2];
  int         rr_mode[2] = '{0, 0};
  bit         prev_valid[2], prev_hs[2];
  logic [3:0] prev_data[2];
  logic       prev_mis[2];
  int         checks = 0;
  int         errors = 0;

  function automatic int hold_of(input int k);
    return (k == 0) ? H0 : H1;
  endfunction

  function automatic bit ver_of(input int k);
    return (k == 0) ? V0 : V1;
  endfunction

  function automatic int sb_size(input int k);
    return (k == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic void sb_push(input int k, input exp_t e);
    if (k == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endfunction

  function automatic exp_t sb_front(input int k);
    return (k == 0) ? sb0[0] : sb1[0];
  endfunction

  function automatic exp_t sb_pop(input int k);
    if (k == 0) return sb0.pop_front();
    return sb1.pop_front();
  endfunction

  // Cycle index relative to the accept edge at time t (1 = SETUP cycle).
  function automatic int cyc_since(input time t);
    return int'(($time - t - 5) / 10) + 1;
  endfunction

  task automatic chk(input int k, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t actual=%0h expected=%0h", name, k, $time, act, exp);
    end
  endtask

  task automatic reset_checks();
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_req_ready", 32'(req_ready[k]), 32'd1);
      chk(k, "rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      chk(k, "rst_rsp_data", 32'(rsp_data[k]), 32'd0);
      chk(k, "rst_rsp_mis", 32'(rsp_mis[k]), 32'd0);
      chk(k, "rst_ram_addr", 32'(ram_addr[k]), 32'd0);
      chk(k, "rst_ram_data", 32'(ram_data[k]), 32'd0);
      chk(k, "rst_ram_write", 32'(ram_write[k]), 32'd0);
    end
  endtask

  task automatic clear_model();
    sb0.delete();
    sb1.delete();
    for (int k = 0; k < 2; k++) begin
      busy[k] = 1'b0;
      rel[k]  = 1'b0;
      have[k] = 1'b0;
    end
  endtask

  task automatic issue(input int k, input bit w, input logic [3:0] a, input logic [3:0] d);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    req_write[k] = w;
    req_addr[k]  = a;
    req_data[k]  = d;
    req_valid[k] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[k] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[k]) begin
      chk(k, "accept_timeout", 32'(req_ready[k]), 32'd1);
      req_valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    // Reference: a write stores d; the response is whatever the RAM returns for that word.
    if (w) begin
      ref_mem[k][a] = d;
      e.d = (bad[k] && a == 4'hF) ? 4'h3 : d;
      e.m = ver_of(k) && (e.d != d);
    end else begin
      e.d = (bad[k] && a == 4'hF) ? 4'h3 : ref_mem[k][a];
      e.m = 1'b0;
    end
    e.w = w;
    e.t = $time;
    sb_push(k, e);
    busy[k]  = 1'b1;
    have[k]  = 1'b1;
    cur_a[k] = a;
    cur_d[k] = d;
    cur_w[k] = w;
    cur_t[k] = $time;
    #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while ((busy[k] || sb_size(k) != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) chk(k, "idle_timeout", 32'(sb_size(k)), 32'd0);
  endtask

  task automatic mon(input int k);
    exp_t e;
    int   j;
    bit   hs;
    if (rst) begin
      prev_valid[k] = 1'b0;
      prev_hs[k]    = 1'b0;
      return;
    end
    if (rel[k]) begin
      busy[k] = 1'b0;
      rel[k]  = 1'b0;
    end
    chk(k, "req_ready", 32'(req_ready[k]), 32'(!busy[k]));
    if (have[k]) begin
      chk(k, "ram_addr", 32'(ram_addr[k]), 32'(cur_a[k]));
      if (cur_w[k]) chk(k, "ram_data", 32'(ram_data[k]), 32'(cur_d[k]));
    end
    j = busy[k] ? cyc_since(cur_t[k]) : 0;
    chk(k, "ram_write", 32'(ram_write[k]), 32'(busy[k] && cur_w[k] && j == 2));
    hs = 1'b0;
    if (rsp_valid[k] && !prev_valid[k]) begin
      if (sb_size(k) == 0) begin
        chk(k, "rsp_valid_unexpected", 32'(rsp_valid[k]), 32'd0);
      end else begin
        e = sb_front(k);
        chk(k, "rsp_latency", 32'(j), 32'(e.w ? 3 + hold_of(k) : 3));
      end
    end
    if (prev_valid[k] && !prev_hs[k]) begin
      chk(k, "rsp_valid_held", 32'(rsp_valid[k]), 32'd1);
      chk(k, "rsp_data_stable", 32'(rsp_data[k]), 32'(prev_data[k]));
      chk(k, "rsp_mis_stable", 32'(rsp_mis[k]), 32'(prev_mis[k]));
    end
    if (rsp_valid[k] && rsp_ready[k] && sb_size(k) != 0) begin
      e = sb_pop(k);
      chk(k, "rsp_data", 32'(rsp_data[k]), 32'(e.d));
      chk(k, "rsp_mismatch", 32'(rsp_mis[k]), 32'(e.m));
      rel[k] = 1'b1;
      hs     = 1'b1;
    end
    prev_valid[k] = rsp_valid[k];
    prev_data[k]  = rsp_data[k];
    prev_mis[k]   = rsp_mis[k];
    prev_hs[k]    = hs;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0);
      mon(1);
    end
  end

  // Response back-pressure: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    rsp_ready = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        case (rr_mode[k])
          0:       rsp_ready[k] = 1'b1;
          1:       rsp_ready[k] = ($urandom_range(0, 2) != 0);
          default: rsp_ready[k] = 1'b0;
        endcase
      end
    end
  end

  task automatic run_seq(input int k);
    int n;
    rr_mode[k] = 0;
    issue(k, 1'b1, 4'd5, 4'hA);
    wait_idle(k);
    issue(k, 1'b0, 4'd5, 4'h0);
    wait_idle(k);
    bad[k] = 1'b1;
    issue(k, 1'b1, 4'hF, 4'h6);
    wait_idle(k);
    bad[k] = 1'b0;
    issue(k, 1'b0, 4'hF, 4'h0);
    wait_idle(k);
    // Back-to-back writes with the first response stalled for five cycles.
    rr_mode[k] = 2;
    issue(k, 1'b1, 4'd9, 4'hC);
    fork
      issue(k, 1'b1, 4'd10, 4'h4);
      begin
        n = 0;
        while (!rsp_valid[k] && n < 100) begin
          @(negedge clk);
          n++;
        end
        if (n >= 100) chk(k, "stall_rsp_timeout", 32'(rsp_valid[k]), 32'd1);
        repeat (5) @(posedge clk);
        rr_mode[k] = 0;
      end
    join
    wait_idle(k);
    rr_mode[k] = 1;
    repeat (120) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    wait_idle(k);
    rr_mode[k] = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [3:0] old;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_data  = '0;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 16; a++) ref_mem[k][a] = 4'h0;
    clear_model();

    // Reset raised between clock edges must act at once.
    #3 rst = 1'b1;
    #1 reset_checks();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    fork
      run_seq(0);
      run_seq(1);
    join

    // Reset during the strobe of a write to address 3: the write is abandoned.
    old = ref_mem[0][3];
    issue(0, 1'b1, 4'd3, old ^ 4'hF);
    n = 0;
    @(negedge clk);
    while (!ram_write[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(0, "strobe_seen", 32'(ram_write[0]), 32'd1);
    #2 rst = 1'b1;
    clear_model();
    ref_mem[0][3] = old;
    #1 reset_checks();
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (10) @(posedge clk);
    issue(0, 1'b0, 4'd3, 4'h0);
    wait_idle(0);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
